// File: rtl/jt49_cenctl.sv
// -----------------------------------------------------------------------------
// jt49_cenctl
//
// Fractional clock-enable generator for the PSG divider, with a handshaked
// reconfiguration path that only swaps the rate at an epoch boundary.
//
// A W-bit accumulator adds the effective numerator min(num, den) every running
// cycle and subtracts den whenever the sum reaches den. Each subtraction
// produces one registered cen pulse. The result is an average rate of
// num/den pulses per clock, or one pulse per clock when num >= den.
//
// An epoch is 2^EPW cen pulses. A new configuration is only applied right
// after the last pulse of an epoch, so the divider never sees a rate or sel
// change in the middle of an epoch. The exceptions are when the generator is
// stopped (num or den is zero) or halted, because no pulses would ever arrive
// to close the epoch.
//
// Handshake: IDLE -> PEND -> APPLY -> DROP -> IDLE
//   IDLE  : cfg_req high captures cfg_num/den/sel into shadow registers.
//   PEND  : waits for the next epoch boundary, or moves on immediately when
//           the generator is stopped or halted.
//   APPLY : loads the shadow values, clears acc and ep, and raises cfg_ack
//           for one cycle.
//   DROP  : waits for the requester to release cfg_req.
//
// Ports
//   clk      in   system clock, all state changes on posedge
//   rst_n    in   asynchronous active-low reset
//   halt     in   freezes cen generation (acc and ep hold) while high
//   cfg_req  in   configuration request, level, held until cfg_ack
//   cfg_num  in   [W-1:0] requested numerator
//   cfg_den  in   [W-1:0] requested denominator
//   cfg_sel  in   requested divide select
//   cfg_ack  out  one-cycle pulse, new configuration now in effect
//   cen      out  registered base clock enable
//   sel      out  registered divide select
//   busy     out  high whenever the handshake FSM is not in IDLE
// -----------------------------------------------------------------------------
module jt49_cenctl #(
   parameter int W       = 16,
   parameter int EPW     = 3,
   parameter int RST_NUM = 1,
   parameter int RST_DEN = 2,
   parameter int RST_SEL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         halt,
   input  logic         cfg_req,
   input  logic [W-1:0] cfg_num,
   input  logic [W-1:0] cfg_den,
   input  logic         cfg_sel,
   output logic         cfg_ack,
   output logic         cen,
   output logic         sel,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      APPLY = 2'd2,
      DROP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t           state_q,   state_d;
   logic [W-1:0]     acc_q,     acc_d;
   logic [EPW-1:0]   ep_q,      ep_d;
   logic [W-1:0]     num_q,     num_d;
   logic [W-1:0]     den_q,     den_d;
   logic             sel_q,     sel_d;
   logic             cen_q,     cen_d;
   logic             cfg_ack_q, cfg_ack_d;
   logic [W-1:0]     sh_num_q,  sh_num_d;
   logic [W-1:0]     sh_den_q,  sh_den_d;
   logic             sh_sel_q,  sh_sel_d;

   // ---------------------------------------------------------------------------
   // Accumulator datapath
   // ---------------------------------------------------------------------------
   logic [W-1:0]     eff_num;
   logic [W:0]       sum;
   logic             hit;
   logic             stopped;
   logic             run;
   logic             boundary;

   always_comb begin
      // Clamping the numerator to den keeps acc below den, so acc + eff_num
      // never exceeds 2*den-1 and one subtraction per cycle is enough.
      eff_num  = (num_q > den_q) ? den_q : num_q;
      sum      = {1'b0, acc_q} + {1'b0, eff_num};
      hit      = (sum >= {1'b0, den_q});
      stopped  = (num_q == '0) || (den_q == '0);
      run      = !halt && !stopped && (state_q != APPLY);
      // Boundary is the pulse that wraps ep; it is evaluated on the next-state
      // side so PEND can react in the same cycle the pulse is issued.
      boundary = run && hit && (ep_q == '1);
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_d   = state_q;
      acc_d     = acc_q;
      ep_d      = ep_q;
      num_d     = num_q;
      den_d     = den_q;
      sel_d     = sel_q;
      cen_d     = 1'b0;
      cfg_ack_d = 1'b0;
      sh_num_d  = sh_num_q;
      sh_den_d  = sh_den_q;
      sh_sel_d  = sh_sel_q;

      // Rate generator. APPLY takes priority so the new rate starts from a
      // clean accumulator and a fresh epoch.
      if (state_q == APPLY) begin
         num_d     = sh_num_q;
         den_d     = sh_den_q;
         sel_d     = sh_sel_q;
         acc_d     = '0;
         ep_d      = '0;
         cfg_ack_d = 1'b1;
      end else if (run) begin
         if (hit) begin
            // Modular W-bit subtraction is exact: the true result is < den.
            acc_d = sum[W-1:0] - den_q;
            cen_d = 1'b1;
            ep_d  = ep_q + EPW'(1);
         end else begin
            acc_d = sum[W-1:0];
         end
      end else if (stopped && !halt) begin
         acc_d = '0;
      end

      // Configuration handshake
      unique case (state_q)
         IDLE: begin
            // A boundary coinciding with capture is not seen by PEND, which
            // only starts looking on the following cycle.
            if (cfg_req) begin
               sh_num_d = cfg_num;
               sh_den_d = cfg_den;
               sh_sel_d = cfg_sel;
               state_d  = PEND;
            end
         end
         PEND: begin
            if (boundary || stopped || halt) state_d = APPLY;
         end
         APPLY: begin
            state_d = DROP;
         end
         DROP: begin
            if (!cfg_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: the shadow registers are small flops, not a memory, so they take
   // the asynchronous reset like the rest of the state and come up as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         ep_q      <= '0;
         num_q     <= W'(RST_NUM);
         den_q     <= W'(RST_DEN);
         sel_q     <= 1'(RST_SEL);
         cen_q     <= 1'b0;
         cfg_ack_q <= 1'b0;
         sh_num_q  <= '0;
         sh_den_q  <= '0;
         sh_sel_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         acc_q     <= acc_d;
         ep_q      <= ep_d;
         num_q     <= num_d;
         den_q     <= den_d;
         sel_q     <= sel_d;
         cen_q     <= cen_d;
         cfg_ack_q <= cfg_ack_d;
         sh_num_q  <= sh_num_d;
         sh_den_q  <= sh_den_d;
         sh_sel_q  <= sh_sel_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign cen     = cen_q;
   assign sel     = sel_q;
   assign cfg_ack = cfg_ack_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_jt49_cenctl.sv
// -----------------------------------------------------------------------------
// tb_jt49_cenctl
//
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. On every clock a reference model predicts cen, sel, cfg_ack and
// busy. The model derives pulses from the closed form
// floor(k*e/d) - floor((k-1)*e/d), where k is the number of running cycles
// since the last configuration load. Epoch boundaries come from the total
// pulse count since that load.
// -----------------------------------------------------------------------------
module tb_jt49_cenctl;

   localparam int W   = 16;
   localparam int EPW = 3;

   localparam int HS_IDLE  = 0;
   localparam int HS_WAIT  = 1;
   localparam int HS_APPLY = 2;
   localparam int HS_DROP  = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         halt = 1'b0;
   logic         cfg_req = 1'b0;
   logic [W-1:0] cfg_num = '0;
   logic [W-1:0] cfg_den = '0;
   logic         cfg_sel = 1'b0;
   logic         cfg_ack;
   logic         cen;
   logic         sel;
   logic         busy;

   jt49_cenctl #(
      .W(W), .EPW(EPW), .RST_NUM(1), .RST_DEN(2), .RST_SEL(1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .halt    (halt),
      .cfg_req (cfg_req),
      .cfg_num (cfg_num),
      .cfg_den (cfg_den),
      .cfg_sel (cfg_sel),
      .cfg_ack (cfg_ack),
      .cen     (cen),
      .sel     (sel),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Reference model state
   int     m_hs;
   longint m_k;
   longint m_pulses;
   int     m_num, m_den, m_sel;
   int     m_sh_num, m_sh_den, m_sh_sel;
   bit     m_cen, m_ack;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic m_reset();
      m_hs = HS_IDLE;
      m_k = 0;
      m_pulses = 0;
      m_num = 1;
      m_den = 2;
      m_sel = 1;
      m_sh_num = 0;
      m_sh_den = 0;
      m_sh_sel = 0;
      m_cen = 0;
      m_ack = 0;
   endtask

   // One clock of the reference model, fed by the current inputs.
   task automatic m_clock();
      bit     stopped;
      bit     bnd;
      longint e;
      int     old_hs;
      if (!rst_n) begin
         m_reset();
         return;
      end
      stopped = (m_num == 0) || (m_den == 0);
      bnd     = 0;
      old_hs  = m_hs;
      if (old_hs == HS_APPLY) begin
         m_num = m_sh_num;
         m_den = m_sh_den;
         m_sel = m_sh_sel;
         m_k = 0;
         m_pulses = 0;
         m_cen = 0;
         m_ack = 1;
      end else begin
         m_ack = 0;
         if (halt || stopped) begin
            m_cen = 0;
         end else begin
            m_k++;
            e = (m_num < m_den) ? m_num : m_den;
            m_cen = ((m_k * e) / m_den) != (((m_k - 1) * e) / m_den);
            if (m_cen) begin
               m_pulses++;
               bnd = (m_pulses % (1 << EPW)) == 0;
            end
         end
      end
      case (old_hs)
         HS_IDLE: if (cfg_req) begin
            m_sh_num = int'(cfg_num);
            m_sh_den = int'(cfg_den);
            m_sh_sel = int'(cfg_sel);
            m_hs = HS_WAIT;
         end
         HS_WAIT:  if (bnd || stopped || halt) m_hs = HS_APPLY;
         HS_APPLY: m_hs = HS_DROP;
         default:  if (!cfg_req) m_hs = HS_IDLE;
      endcase
   endtask

   // Advance one clock and compare every output with the model.
   task automatic step();
      @(posedge clk);
      m_clock();
      @(negedge clk);
      cyc++;
      check("cen",     cen,     m_cen);
      check("sel",     sel,     m_sel);
      check("cfg_ack", cfg_ack, m_ack);
      check("busy",    busy,    m_hs != HS_IDLE);
   endtask

   // Called at a negedge: assert reset, check the asynchronous effect, hold
   // through one posedge and release.
   task automatic do_reset();
      rst_n = 1'b0;
      m_reset();
      #1;
      check("rst_cen",  cen,     0);
      check("rst_sel",  sel,     1);
      check("rst_ack",  cfg_ack, 0);
      check("rst_busy", busy,    0);
      step();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic cfg_raise(input int n, input int d, input int s);
      cfg_num = W'(n);
      cfg_den = W'(d);
      cfg_sel = s[0];
      cfg_req = 1'b1;
   endtask

   task automatic wait_ack(input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (cfg_ack === 1'b1) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout at cycle %0d: no cfg_ack within %0d cycles", cyc, budget);
   endtask

   task automatic do_cfg(input int n, input int d, input int s);
      cfg_raise(n, d, s);
      wait_ack(400);
      cfg_req = 1'b0;
      step();
   endtask

   int pulses, acks, busys, consec, t0;
   bit prev;

   initial begin
      m_reset();
      @(negedge clk);
      do_reset();

      // Default rate 1/2, sel=1, no ack
      pulses = 0;
      acks = 0;
      repeat (20) begin
         step();
         pulses += int'(cen);
         acks   += int'(cfg_ack);
      end
      check("def_pulses", pulses, 10);
      check("def_acks",   acks,   0);
      check("def_sel",    sel,    1);

      // 3/7 rate: 300 pulses in 700 cycles, never two in a row
      do_cfg(3, 7, 1);
      pulses = 0;
      consec = 0;
      prev = cen;
      repeat (700) begin
         step();
         pulses += int'(cen);
         if (prev && cen) consec++;
         prev = cen;
      end
      check("frac_pulses", pulses, 300);
      check("frac_consec", consec, 0);

      // Boundary apply: request after ep reaches 2, boundary pulse at cycle 16
      do_reset();
      repeat (4) step();
      cfg_raise(1, 4, 0);
      wait_ack(100);
      check("bnd_ack_cycle", cyc, 17);
      check("bnd_sel",       sel, 0);
      cfg_req = 1'b0;
      t0 = cyc;
      for (int i = 0; i < 20; i++) begin
         step();
         if (cen === 1'b1) break;
      end
      check("bnd_next_cen", cyc - t0, 4);

      // Stopped path: den=0, then a new request applies right away
      do_cfg(1, 0, 0);
      t0 = cyc;
      cfg_raise(1, 1, 1);
      wait_ack(50);
      check("stop_latency", cyc - t0, 3);
      cfg_req = 1'b0;
      pulses = 0;
      repeat (5) begin
         step();
         pulses += int'(cen);
      end
      check("stop_1of1", pulses, 5);

      // Halt path at default rate
      do_reset();
      halt = 1'b1;
      t0 = cyc;
      cfg_raise(1, 3, 0);
      wait_ack(50);
      check("halt_latency", cyc - t0, 3);
      cfg_req = 1'b0;
      pulses = 0;
      repeat (6) begin
         step();
         pulses += int'(cen);
      end
      check("halt_quiet", pulses, 0);
      halt = 1'b0;
      pulses = 0;
      repeat (6) begin
         step();
         pulses += int'(cen);
      end
      check("halt_resume", pulses, 2);

      // Clamp num > den, with cfg_req held well past the ack
      cfg_raise(9, 5, 1);
      wait_ack(100);
      acks = int'(cfg_ack);
      busys = 0;
      repeat (10) begin
         step();
         acks  += int'(cfg_ack);
         busys += int'(busy);
      end
      check("hold_acks", acks,  1);
      check("hold_busy", busys, 10);
      cfg_req = 1'b0;
      step();
      check("hold_idle", busy, 0);
      pulses = 0;
      repeat (20) begin
         step();
         pulses += int'(cen);
      end
      check("clamp_pulses", pulses, 20);

      // Reset while PEND aborts; a still-high request is captured again
      do_reset();
      cfg_raise(2, 3, 0);
      step();
      step();
      check("pend_busy", busy, 1);
      do_reset();
      wait_ack(100);
      check("rerq_ack_cycle", cyc, 17);
      cfg_req = 1'b0;
      step();

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            halt = ($urandom_range(0, 9) == 0);
            if (!cfg_req && m_hs == HS_IDLE && $urandom_range(0, 3) == 0)
               cfg_raise($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 1));
            else if (cfg_req && m_hs == HS_DROP && $urandom_range(0, 2) == 0)
               cfg_req = 1'b0;
            else if (cfg_req && m_hs != HS_DROP) begin
               cfg_num = W'($urandom_range(0, 12));
               cfg_den = W'($urandom_range(0, 12));
               cfg_sel = 1'($urandom_range(0, 1));
            end
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
